// File: rtl/scope_scan_reader_pkg.sv
// Shared types and helpers for the scope scan reader.
package scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } scan_state_e;

  localparam int MAX_LANES = 16;

  // Width of a lane index; a single lane still gets a one-bit index.
  function automatic int lane_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/scope_scan_lane.sv
// One free-running lane counter; wraps modulo 2^WIDTH.
module scope_scan_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up by one on every enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/scope_scan_reader.sv
// Snapshots NUM_LANES lane counters on a scan request and streams them out,
// lane 0 first, over a valid/ready interface.
// Optional build macro: SCAN_PARITY_EN adds out_parity and per-entry parity.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for scan_req; a request captures all lane counters
// EMIT  | presenting snap[idx]; advances on each accepted word
module scope_scan_reader
  import scan_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int WIDTH     = 32,
  localparam int LANE_W    = lane_w(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] lane_inc,
  input  logic                 scan_req,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [LANE_W-1:0]    out_lane,
`ifdef SCAN_PARITY_EN
  output logic                 out_parity,
`endif
  output logic                 out_last
);

  scan_state_e       state, state_nxt;
  logic [WIDTH-1:0]  counts [NUM_LANES];
  logic [WIDTH-1:0]  snap   [NUM_LANES];
  logic [WIDTH-1:0]  sel_data;
  logic [LANE_W-1:0] idx;
  logic              capture;
  logic              xfer;
  logic              last_w;

  assign out_valid = (state == EMIT);
  assign busy      = out_valid;
  assign xfer      = out_valid & out_ready;

  // Each lane owns its counter inside its own named scope.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [WIDTH-1:0] cnt;

    scope_scan_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .inc   (lane_inc[i]),
      .count (cnt)
    );

    assign counts[i] = cnt;
  end

  // A single lane needs no index register: its only word is also the last.
  if (NUM_LANES == 1) begin : g_idx_single
    assign idx    = '0;
    assign last_w = 1'b1;
  end else begin : g_idx_multi
    logic [LANE_W-1:0] idx_q;

    // Index clears on capture and steps on every non-final transfer.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 idx_q <= '0;
      else if (capture)        idx_q <= '0;
      else if (xfer && !last_w) idx_q <= idx_q + 1'b1;
    end

    // Final-lane detect against the highest legal index.
    always_comb begin
      last_w = 1'b0;
      begin
        logic [LANE_W-1:0] top_idx;
        top_idx = LANE_W'(NUM_LANES - 1);
        last_w  = (idx_q == top_idx);
      end
    end

    assign idx = idx_q;
  end

  case (NUM_LANES)
    1: begin : g_sel_single
      assign sel_data = snap[0];
    end
    default: begin : g_sel_multi
      assign sel_data = snap[idx];
    end
  endcase

  // Outputs read zero outside EMIT so IDLE looks like reset.
  assign out_data = out_valid ? sel_data : '0;
  assign out_lane = out_valid ? idx : '0;
  assign out_last = out_valid & last_w;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; requests only count in IDLE, so one on the last transfer is dropped.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (scan_req) begin
          capture   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (xfer && last_w) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot takes the pre-increment counter values of the request cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) snap[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_LANES; i++) snap[i] <= counts[i];
    end
  end

`ifdef SCAN_PARITY_EN
  logic snap_par [NUM_LANES];
  logic sel_par;

  // Parity is computed once at capture rather than on the output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) snap_par[i] <= 1'b0;
    end else if (capture) begin
      for (int i = 0; i < NUM_LANES; i++) snap_par[i] <= ^counts[i];
    end
  end

  case (NUM_LANES)
    1: begin : g_par_single
      assign sel_par = snap_par[0];
    end
    default: begin : g_par_multi
      assign sel_par = snap_par[idx];
    end
  endcase

  assign out_parity = out_valid & sel_par;
`endif

endmodule

// File: tb/tb_scope_scan_reader.sv
// Directed bench for scope_scan_reader: a 4-lane/32-bit instance for the
// main stream behaviour and a 1-lane/4-bit instance for wrap and single-lane.
module tb_scope_scan_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  lane_inc;
  logic        scan_req, out_ready;
  logic        busy, out_valid, out_last;
  logic [31:0] out_data;
  logic [1:0]  out_lane;

  logic [0:0]  lane_inc1;
  logic        scan_req1, out_ready1;
  logic        busy1, out_valid1, out_last1;
  logic [3:0]  out_data1;
  logic [0:0]  out_lane1;

`ifdef SCAN_PARITY_EN
  logic        out_parity, out_parity1;
`endif

  scope_scan_reader #(.NUM_LANES(4), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .lane_inc  (lane_inc),
    .scan_req  (scan_req),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
`ifdef SCAN_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_last  (out_last)
  );

  scope_scan_reader #(.NUM_LANES(1), .WIDTH(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .lane_inc  (lane_inc1),
    .scan_req  (scan_req1),
    .busy      (busy1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1),
    .out_lane  (out_lane1),
`ifdef SCAN_PARITY_EN
    .out_parity(out_parity1),
`endif
    .out_last  (out_last1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]       mask;
    int               ncyc;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full scan with out_ready held high, checking every word.
  task automatic scan4(input string tag, input logic [3:0][31:0] e);
    scan_req  = 1'b1;
    out_ready = 1'b1;
    tick();
    scan_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s w%0d valid", tag, k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("%s w%0d busy",  tag, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s w%0d lane",  tag, k), {30'd0, out_lane}, k);
      chk($sformatf("%s w%0d data",  tag, k), out_data, e[k]);
      chk($sformatf("%s w%0d last",  tag, k), {31'd0, out_last}, (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk({tag, " end busy"},  {31'd0, busy}, 32'd0);
    chk({tag, " end valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{mask: 4'b0000, ncyc: 0, exp: {32'd0, 32'd0, 32'd0, 32'd0}};
    vecs[1] = '{mask: 4'b0100, ncyc: 5, exp: {32'd0, 32'd5, 32'd0, 32'd0}};
    vecs[2] = '{mask: 4'b1011, ncyc: 3, exp: {32'd3, 32'd5, 32'd3, 32'd3}};
    vecs[3] = '{mask: 4'b1111, ncyc: 2, exp: {32'd5, 32'd7, 32'd5, 32'd5}};

    rst = 1'b1;
    lane_inc = '0; scan_req = 1'b0; out_ready = 1'b0;
    lane_inc1 = '0; scan_req1 = 1'b0; out_ready1 = 1'b0;
    tick();
    tick();
    chk("rst busy",  {31'd0, busy}, 32'd0);
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst last",  {31'd0, out_last}, 32'd0);
    chk("rst data",  out_data, 32'd0);
    chk("rst lane",  {30'd0, out_lane}, 32'd0);
    rst = 1'b0;
    tick();

    // Table: increment pattern, then a full scan against cumulative counts.
    for (int v = 0; v < 4; v++) begin
      lane_inc = vecs[v].mask;
      for (int c = 0; c < vecs[v].ncyc; c++) tick();
      lane_inc = '0;
      scan4($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Pre-increment snapshot: lane 2 is 7 at request, keeps counting (5 more).
    lane_inc = 4'b0100;
    scan4("preinc", {32'd5, 32'd7, 32'd5, 32'd5});
    lane_inc = '0;
    scan4("live", {32'd5, 32'd12, 32'd5, 32'd5});

    // Backpressure on lane 1 for three cycles.
    scan_req = 1'b1; out_ready = 1'b1;
    tick();
    scan_req = 1'b0;
    chk("bp lane0", {30'd0, out_lane}, 32'd0);
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("bp stall%0d lane", s),  {30'd0, out_lane}, 32'd1);
      chk($sformatf("bp stall%0d data", s),  out_data, 32'd5);
      chk($sformatf("bp stall%0d valid", s), {31'd0, out_valid}, 32'd1);
      tick();
    end
    chk("bp held lane", {30'd0, out_lane}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp lane2", {30'd0, out_lane}, 32'd2);
    chk("bp data2", out_data, 32'd12);
    tick();
    chk("bp lane3", {30'd0, out_lane}, 32'd3);
    chk("bp last3", {31'd0, out_last}, 32'd1);
    tick();
    chk("bp done", {31'd0, busy}, 32'd0);

    // Requests during EMIT, including on the final transfer, are dropped.
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    tick();
    chk("ign at lane1", {30'd0, out_lane}, 32'd1);
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    chk("ign no restart", {30'd0, out_lane}, 32'd2);
    chk("ign data2", out_data, 32'd12);
    tick();
    chk("ign last", {31'd0, out_last}, 32'd1);
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    chk("ign final valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("ign stays idle", {31'd0, busy}, 32'd0);

    // Mid-scan reset drops the stream at once and clears the counters.
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    tick();
    tick();
    chk("mrst at lane2", {30'd0, out_lane}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mrst valid", {31'd0, out_valid}, 32'd0);
    chk("mrst busy",  {31'd0, busy}, 32'd0);
    chk("mrst data",  out_data, 32'd0);
    chk("mrst lane",  {30'd0, out_lane}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    scan4("post rst", {32'd0, 32'd0, 32'd0, 32'd0});

    // Single lane, WIDTH 4: 17 increments wrap to 1; the first word is last.
    lane_inc1 = 1'b1;
    for (int c = 0; c < 17; c++) tick();
    lane_inc1 = 1'b0;
    scan_req1 = 1'b1; out_ready1 = 1'b1;
    tick();
    scan_req1 = 1'b0;
    chk("wrap valid", {31'd0, out_valid1}, 32'd1);
    chk("wrap data",  {28'd0, out_data1}, 32'd1);
    chk("wrap lane",  {31'd0, out_lane1}, 32'd0);
    chk("wrap last",  {31'd0, out_last1}, 32'd1);
    tick();
    chk("wrap done valid", {31'd0, out_valid1}, 32'd0);
    chk("wrap done busy",  {31'd0, busy1}, 32'd0);

`ifdef SCAN_PARITY_EN
    chk("par idle", {31'd0, out_parity1}, 32'd0);
    lane_inc1 = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    lane_inc1 = 1'b0;
    scan_req1 = 1'b1;
    tick();
    scan_req1 = 1'b0;
    chk("par7 data", {28'd0, out_data1}, 32'd7);
    chk("par7 bit",  {31'd0, out_parity1}, 32'd1);
    tick();
    lane_inc1 = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    lane_inc1 = 1'b0;
    scan_req1 = 1'b1;
    tick();
    scan_req1 = 1'b0;
    chk("par3 data", {28'd0, out_data1}, 32'd3);
    chk("par3 bit",  {31'd0, out_parity1}, 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
